// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: the sweep FSM state,
// default geometry and a helper that locates a port's slice in a packed bus.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int RF_A0 = 10;

    // LSB of port `port` inside a packed bus of `width`-bit fields
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write flags, one per register: long-latency producers set a flag,
// the eventual writeback clears it, and each read port looks its flag up.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_AW,
    parameter int NUM_READ      = 2,
    parameter int BYPASS        = 1
) (
    input  logic                              clk_i,
    input  logic                              clr_i,
    input  logic                              set_i,
    input  logic [ADDRESS_WIDTH-1:0]          set_addr_i,
    input  logic                              wr_i,
    input  logic [ADDRESS_WIDTH-1:0]          wr_addr_i,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [NUM_READ-1:0]               rd_busy_o
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;

    logic [DEPTH-1:0] busy_q, busy_d;

    // Set is applied after clear so a newly issued producer supersedes a
    // writeback landing on the same register in the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (wr_i)  busy_d[wr_addr_i]  = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        localparam int AL = port_lsb(i, ADDRESS_WIDTH);
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     fwd;
        assign addr = rd_addr_i[AL +: ADDRESS_WIDTH];
        assign fwd  = (BYPASS != 0) && wr_i && (wr_addr_i == addr);
        assign rd_busy_o[i] = busy_q[addr] & ~fwd;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with x0 tied to zero, optional
// write-to-read forwarding, a post-reset clear sweep and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_AW,
    parameter int DATA_WIDTH    = RF_DW,
    parameter int NUM_READ      = 2,
    parameter int BYPASS        = 1,
    parameter int A0_INDEX      = RF_A0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]               rd_busy,
    input  logic                              we,
    input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              busy_set,
    input  logic [ADDRESS_WIDTH-1:0]          busy_addr,
    output logic                              ready,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;

    rf_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    regs_q [DEPTH];
    logic                     clearing;
    logic                     wr_en;
    logic [NUM_READ-1:0]      sb_busy;

    assign clearing = (state_q == RF_CLEAR);
    assign ready    = (state_q == RF_RUN);
    assign wr_en    = we & ~clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + ADDRESS_WIDTH'(1);
                if (cnt_q == '1) state_d = RF_RUN;
            end
            default: ;
        endcase
    end

    // Storage has no reset of its own; the sweep zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing)
                regs_q[cnt_q] <= '0;
            else if (we && wr_addr != '0)
                regs_q[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_READ      (NUM_READ),
        .BYPASS        (BYPASS)
    ) u_sb (
        .clk_i      (clk),
        .clr_i      (rst | clearing),
        .set_i      (busy_set & ~clearing),
        .set_addr_i (busy_addr),
        .wr_i       (wr_en),
        .wr_addr_i  (wr_addr),
        .rd_addr_i  (rd_addr),
        .rd_busy_o  (sb_busy)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        localparam int AL = port_lsb(i, ADDRESS_WIDTH);
        localparam int DL = port_lsb(i, DATA_WIDTH);
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     fwd;
        assign addr = rd_addr[AL +: ADDRESS_WIDTH];
        assign fwd  = (BYPASS != 0) && wr_en && (wr_addr == addr);
        assign rd_data[DL +: DATA_WIDTH] = (clearing || addr == '0) ? '0 :
                                           fwd ? wr_data : regs_q[addr];
        assign rd_busy[i] = sb_busy[i] & ~clearing;
    end

    assign a0 = clearing ? '0 : regs_q[A0_INDEX];

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file. Successor to the single-instruction-decoded 2R1W register file.
- Explicit address ports; x0 hardwired to zero; optional write-to-read bypass.
- Post-reset clear sweep FSM and a per-register pending-write scoreboard for multi-cycle writeback (loads, divider).
- Sits in the decode stage; the hazard unit consumes rd_busy and ready.

Parameters:
- ADDRESS_WIDTH, 5: register index width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32: register width.
- NUM_READ, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only.
- A0_INDEX, 10: register exported on a0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_READ*ADDRESS_WIDTH  packed read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, combinational.
- rd_busy  out  NUM_READ  pending-write flag per read port, combinational.
- we  in  1  write enable.
- wr_addr  in  ADDRESS_WIDTH  write index.
- wr_data  in  DATA_WIDTH  write data.
- busy_set  in  1  mark busy_addr as pending (long-latency producer issued).
- busy_addr  in  ADDRESS_WIDTH  index to mark pending.
- ready  out  1  high when clear sweep has finished.
- a0  out  DATA_WIDTH  stored value of register A0_INDEX, no bypass.

Behaviour:
- Reset and state machine:
  - rst=1 at posedge: FSM enters CLEAR; sweep counter = 0; all busy bits = 0; ready = 0.
  - rst may assert at any time, including mid-sweep. The sweep always restarts at index 0.
- CLEAR state:
  - Each cycle, writes 0 to registers[counter] and increments the counter.
  - After writing index 2**AW-1, the FSM moves to RUN and ready=1 on the next cycle.
  - Sweep duration: exactly 2**AW cycles after rst deasserts (32 cycles by default).
- During CLEAR:
  - we and busy_set are ignored.
  - rd_data = 0, rd_busy = 0, a0 = 0.
- RUN state (holds until rst):
  - we=1 and wr_addr!=0: registers[wr_addr] <= wr_data.
  - we=1 and wr_addr==0: write dropped.
- Read, port i:
  - rd_addr_i==0: rd_data_i = 0.
  - BYPASS=1, we=1 and wr_addr==rd_addr_i!=0: rd_data_i = wr_data.
  - Otherwise: rd_data_i = registers[rd_addr_i].
- Scoreboard, one bit per register:
  - we=1 at wr_addr clears the bit.
  - busy_set=1 at busy_addr sets the bit.
  - Set and clear on the same index in the same cycle: set wins (new producer supersedes).
  - busy_set with busy_addr==0 is ignored; bit 0 is always 0.
- rd_busy_i:
  - Equals busy[rd_addr_i].
  - With BYPASS=1, it is forced to 0 when we=1 and wr_addr==rd_addr_i in that cycle, because the value is forwarded.
- a0 = registers[A0_INDEX] as stored; it updates the cycle after the write.
- Reads have no latency. Writes become visible in storage one cycle later.
- Multiple read ports may alias the same index; each returns the same value.

Decomposition:
- Shared package regfile_pkg:
  - FSM enum rf_state_e {RF_CLEAR, RF_RUN}.
  - Localparam defaults: ADDRESS_WIDTH, DATA_WIDTH, A0_INDEX.
  - Function for port-slice extraction.
- One sub-module, regfile_scoreboard:
  - Parametrised by ADDRESS_WIDTH and NUM_READ.
  - Holds busy bits with set/clear/priority and the rd_busy lookup including bypass masking.
  - Takes a sync clear input driven by the CLEAR state.

Test Plan:
1. Pulse rst 1 cycle, hold we=1 wr_addr=5 wr_data=0xDEAD throughout -> ready=0 for 32 cycles, then 1; rd_addr0=5 reads 0 (write during CLEAR ignored).
2. RUN: we=1 wr_addr=0 wr_data=0xFFFF_FFFF, then read rd_addr0=0 -> rd_data0=0. Write x10=0x1234 -> a0=0x1234 from the next cycle.
3. BYPASS=1: same cycle we=1 wr_addr=3 wr_data=0xCAFE, rd_addr0=3, rd_addr1=3 -> both ports read 0xCAFE that cycle. With BYPASS=0 -> old value (0).
4. Scoreboard: busy_set addr=7 -> next cycle rd_busy0=1 for rd_addr0=7. Then we addr=7 data=9 -> rd_busy0=0 that cycle (bypass) and stays 0 after.
5. Same cycle busy_set addr=8 and we addr=8 -> bit 8 remains 1 next cycle. busy_set addr=0 -> rd_busy for x0 always 0.
6. Assert rst at sweep cycle 12 -> sweep restarts at 0; ready rises exactly 32 cycles after rst deasserts; all busy bits read 0.
